// File: rtl/sc_fir_bank.sv
// sc_fir_bank: multi-channel stochastic-computing FIR engine.
// One accepted sample vector is filtered on every enabled lane over a
// single stochastic stream of 2^N cycles. All lanes share the tap weights
// (cumulative thresholds plus signs) and the random sources: the stream
// counter t picks the tap, and its bit-reverse (a van der Corput sequence)
// is the comparison threshold for the tap's magnitude.
module sc_fir_bank #(
    parameter int N    = 12,
    parameter int TAPS = 19,
    parameter int CH   = 4,
    parameter int AW   = $clog2(TAPS)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [CH-1:0]       ch_en,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [CH*(N+1)-1:0] in_data,
    input  logic                cfg_we,
    input  logic [AW-1:0]       cfg_addr,
    input  logic [N+1:0]        cfg_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [CH*(N+1)-1:0] out_data,
    output logic                busy
);

    // Lane width (sign-magnitude in, two's complement out) and accumulator width.
    localparam int SW   = N + 1;
    localparam int ACCW = N + 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    // Stream counter; doubles as the tap-select source.
    logic [N-1:0] t_q, t_d;

    // Coefficient table: cumulative thresholds and per-tap signs.
    logic [N:0]      thr_q [TAPS];
    logic [TAPS-1:0] csign_q;

    // Per-lane delay lines, tap 0 holds the newest sample.
    logic [SW-1:0] dl_q [CH][TAPS];

    // Lane enables captured at accept time.
    logic [CH-1:0] en_q;

    logic signed [ACCW-1:0] acc_q [CH];
    logic signed [ACCW-1:0] acc_d [CH];

    logic [CH*SW-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;

    logic          accept;
    logic          last;
    logic          cfg_ok;
    logic [N-1:0]  r_vdc;
    logic          tap_hit;
    logic          tap_csign;
    logic [SW-1:0] tap_smp [CH];

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = ~in_ready;
    assign accept    = in_valid && in_ready;
    assign last      = (t_q == {N{1'b1}});
    assign cfg_ok    = cfg_we && (state_q == S_IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    // State register.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: accept starts a run, the last stream cycle ends it,
    // and the downstream handshake releases the held result.
    always_comb begin
        // NOTE: every always_comb output gets a default before any branch;
        // a path that leaves one unassigned would infer a latch.
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (accept)    state_d = S_RUN;
            S_RUN:   if (last)      state_d = S_DONE;
            S_DONE:  if (out_ready) state_d = S_IDLE;
            default:                state_d = S_IDLE;
        endcase
    end

    // VDC random source: bit-reverse of the stream counter.
    always_comb begin
        r_vdc = '0;
        for (int i = 0; i < N; i++) begin
            r_vdc[i] = t_q[N-1-i];
        end
    end

    // Tap select: lowest k with t < T_k wins (scan downward so the lowest
    // qualifying tap is written last); no hit means no contribution.
    always_comb begin
        tap_hit   = 1'b0;
        tap_csign = 1'b0;
        for (int c = 0; c < CH; c++) begin
            tap_smp[c] = '0;
        end
        for (int k = TAPS - 1; k >= 0; k--) begin
            if ({1'b0, t_q} < thr_q[k]) begin
                tap_hit   = 1'b1;
                tap_csign = csign_q[k];
                for (int c = 0; c < CH; c++) begin
                    tap_smp[c] = dl_q[c][k];
                end
            end
        end
    end

    // Datapath next state: counter, per-lane accumulators and result capture.
    always_comb begin
        t_d         = t_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        for (int c = 0; c < CH; c++) begin
            acc_d[c] = acc_q[c];
        end

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    t_d = '0;
                    for (int c = 0; c < CH; c++) begin
                        acc_d[c] = '0;
                    end
                end
            end
            S_RUN: begin
                t_d = t_q + N'(1);
                for (int c = 0; c < CH; c++) begin
                    // Stochastic bit: selected magnitude beats the VDC value.
                    if (en_q[c] && tap_hit && (tap_smp[c][N-1:0] > r_vdc)) begin
                        if (tap_smp[c][N] ^ tap_csign) begin
                            acc_d[c] = acc_q[c] - ACCW'(1);
                        end else begin
                            acc_d[c] = acc_q[c] + ACCW'(1);
                        end
                    end
                end
                // Final cycle: load results including this cycle's increment.
                if (last) begin
                    out_valid_d = 1'b1;
                    for (int c = 0; c < CH; c++) begin
                        out_data_d[c*SW +: SW] = en_q[c] ? acc_d[c][SW-1:0] : '0;
                    end
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                out_valid_d = 1'b0;
            end
        endcase
    end

    // Datapath registers; enables are latched only when a vector is accepted.
    always_ff @(posedge clock) begin
        if (reset) begin
            t_q         <= '0;
            en_q        <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            for (int c = 0; c < CH; c++) begin
                acc_q[c] <= '0;
            end
        end else begin
            t_q         <= t_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            for (int c = 0; c < CH; c++) begin
                acc_q[c] <= acc_d[c];
            end
            if (accept) begin
                en_q <= ch_en;
            end
        end
    end

    // Delay lines: enabled lanes shift in the new sample on accept,
    // disabled lanes keep their history untouched.
    always_ff @(posedge clock) begin
        // NOTE: these storage arrays are reset on purpose; a cleared history
        // and identity coefficients are the defined post-reset behaviour.
        // Plain data storage without such a requirement would be left unreset.
        if (reset) begin
            for (int c = 0; c < CH; c++) begin
                for (int k = 0; k < TAPS; k++) begin
                    dl_q[c][k] <= '0;
                end
            end
        end else if (accept) begin
            for (int c = 0; c < CH; c++) begin
                if (ch_en[c]) begin
                    dl_q[c][0] <= in_data[c*SW +: SW];
                    for (int k = 1; k < TAPS; k++) begin
                        dl_q[c][k] <= dl_q[c][k-1];
                    end
                end
            end
        end
    end

    // Coefficient table: writable only while idle; addresses past the last
    // tap match no entry and are dropped. Reset restores an identity filter
    // (every threshold at 2^N, all signs positive, so tap 0 always wins).
    always_ff @(posedge clock) begin
        if (reset) begin
            csign_q <= '0;
            for (int k = 0; k < TAPS; k++) begin
                thr_q[k] <= {1'b1, {N{1'b0}}};
            end
        end else if (cfg_ok) begin
            for (int k = 0; k < TAPS; k++) begin
                if (cfg_addr == AW'(k)) begin
                    thr_q[k]   <= cfg_data[N:0];
                    csign_q[k] <= cfg_data[N+1];
                end
            end
        end
    end

endmodule

// File: tb/tb_sc_fir_bank.sv
// tb_sc_fir_bank: directed bench for sc_fir_bank at N=4 (16-cycle streams).
// A behavioural model computes each run's result by counting stream cycles
// straight from the filter definition; a compare process checks handshake
// and data outputs every cycle, and literal expectations pin the model.
module tb_sc_fir_bank;

    localparam int N    = 4;
    localparam int TAPS = 19;
    localparam int CH   = 4;
    localparam int AW   = $clog2(TAPS);
    localparam int SW   = N + 1;
    localparam int DW   = CH * SW;
    localparam int LEN  = 1 << N;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [CH-1:0] ch_en = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          cfg_we = 1'b0;
    logic [AW-1:0] cfg_addr = '0;
    logic [N+1:0]  cfg_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic          busy;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_on   = 1'b0;

    sc_fir_bank #(.N(N), .TAPS(TAPS), .CH(CH), .AW(AW)) dut (
        .clock     (clock),
        .reset     (reset),
        .ch_en     (ch_en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- helpers ----------------
    function automatic logic [SW-1:0] sm(input int v);
        int a;
        a = (v < 0) ? -v : v;
        return {(v < 0) ? 1'b1 : 1'b0, a[N-1:0]};
    endfunction

    function automatic logic [SW-1:0] lane(input int v);
        return v[SW-1:0];
    endfunction

    function automatic logic [DW-1:0] smpack(input int a, input int b, input int c, input int d);
        return {sm(d), sm(c), sm(b), sm(a)};
    endfunction

    function automatic logic [DW-1:0] pack4(input int a, input int b, input int c, input int d);
        return {lane(d), lane(c), lane(b), lane(a)};
    endfunction

    function automatic logic [N+1:0] cfgw(input bit s, input int thr);
        return {s, thr[N:0]};
    endfunction

    // ---------------- behavioural model ----------------
    logic [SW-1:0] m_dl [CH][TAPS];
    int            m_thr [TAPS];
    bit            m_sgn [TAPS];
    int            m_phase;     // 0 idle, 1 streaming, 2 holding result
    int            m_left;
    bit            m_valid;
    logic [DW-1:0] m_data;
    logic [DW-1:0] m_next;

    // Sum of +/-1 over the whole stream: for each t, the first tap whose
    // threshold exceeds t contributes when its magnitude beats bitrev(t).
    function automatic int model_lane(input int ln);
        int acc, r, mag;
        bit neg;
        logic [N-1:0] tv;
        acc = 0;
        for (int t = 0; t < LEN; t++) begin
            tv = t[N-1:0];
            r = 0;
            for (int i = 0; i < N; i++) if (tv[i]) r += 1 << (N - 1 - i);
            for (int k = 0; k < TAPS; k++) begin
                if (t < m_thr[k]) begin
                    mag = int'(m_dl[ln][k][N-1:0]);
                    neg = m_dl[ln][k][N] ^ m_sgn[k];
                    if (mag > r) acc += neg ? -1 : 1;
                    break;
                end
            end
        end
        return acc;
    endfunction

    initial forever begin
        @(posedge clock);
        if (reset) begin
            m_phase = 0;
            m_left  = 0;
            m_valid = 1'b0;
            m_data  = '0;
            m_next  = '0;
            for (int k = 0; k < TAPS; k++) begin
                m_thr[k] = LEN;
                m_sgn[k] = 1'b0;
            end
            for (int c = 0; c < CH; c++)
                for (int k = 0; k < TAPS; k++) m_dl[c][k] = '0;
        end else begin
            case (m_phase)
                0: begin
                    if (cfg_we && int'(cfg_addr) < TAPS) begin
                        m_thr[int'(cfg_addr)] = int'(cfg_data[N:0]);
                        m_sgn[int'(cfg_addr)] = cfg_data[N+1];
                    end
                    if (in_valid) begin
                        for (int c = 0; c < CH; c++) begin
                            if (ch_en[c]) begin
                                for (int k = TAPS - 1; k > 0; k--) m_dl[c][k] = m_dl[c][k-1];
                                m_dl[c][0] = in_data[c*SW +: SW];
                            end
                        end
                        for (int c = 0; c < CH; c++)
                            m_next[c*SW +: SW] = ch_en[c] ? lane(model_lane(c)) : '0;
                        m_phase = 1;
                        m_left  = LEN;
                    end
                end
                1: begin
                    m_left--;
                    if (m_left == 0) begin
                        m_phase = 2;
                        m_valid = 1'b1;
                        m_data  = m_next;
                    end
                end
                default: begin
                    if (out_ready) begin
                        m_phase = 0;
                        m_valid = 1'b0;
                    end
                end
            endcase
        end
    end

    // Per-cycle compare against the model, away from the active edge.
    initial forever begin
        @(negedge clock);
        if (chk_on) begin
            check("in_ready", in_ready, (m_phase == 0));
            check("busy", busy, (m_phase != 0));
            check("out_valid", out_valid, m_valid);
            check("out_data", out_data, m_data);
        end
    end

    // ---------------- stimulus tasks ----------------
    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic cfg_write(input int addr, input bit s, input int thr);
        @(negedge clock);
        cfg_we   = 1'b1;
        cfg_addr = addr[AW-1:0];
        cfg_data = cfgw(s, thr);
        @(negedge clock);
        cfg_we   = 1'b0;
    endtask

    // Presents one vector for one cycle, optionally with a same-cycle cfg write.
    task automatic start_run(input logic [DW-1:0] data, input logic [CH-1:0] en,
                             input bit cw, input int ca, input logic [N+1:0] cd);
        @(negedge clock);
        in_valid = 1'b1;
        in_data  = data;
        ch_en    = en;
        cfg_we   = cw;
        cfg_addr = ca[AW-1:0];
        cfg_data = cd;
        @(negedge clock);
        in_valid = 1'b0;
        cfg_we   = 1'b0;
    endtask

    // Called at the first negedge after the accept edge.
    task automatic wait_result(output logic [DW-1:0] res);
        int n;
        n = 0;
        while (out_valid !== 1'b1 && n < 3 * LEN) begin
            @(negedge clock);
            n++;
        end
        check("result latency", n, LEN);
        res = out_data;
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
        check("valid drops after handshake", out_valid, 1'b0);
    endtask

    task automatic full_run(input string name, input logic [DW-1:0] data,
                            input logic [CH-1:0] en, input logic [DW-1:0] exp);
        logic [DW-1:0] res;
        start_run(data, en, 1'b0, 0, '0);
        wait_result(res);
        check(name, res, exp);
        release_result();
    endtask

    task automatic silent_run(input logic [DW-1:0] data);
        logic [DW-1:0] res;
        start_run(data, 4'hF, 1'b0, 0, '0);
        wait_result(res);
        release_result();
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, failures so far %0d", n_fail);
        $fatal(1, "timeout");
    end

    // ---------------- directed scenarios ----------------
    initial begin
        logic [DW-1:0] res;

        repeat (2) @(negedge clock);
        chk_on = 1'b1;
        reset  = 1'b0;
        check("reset in_ready", in_ready, 1'b1);
        check("reset out_valid", out_valid, 1'b0);
        check("reset out_data", out_data, '0);

        // 1: identity after reset returns exact signed magnitudes.
        full_run("s1 identity", smpack(5, -7, 15, 0), 4'hF, pack4(5, -7, 15, 0));

        // 2: two-tap weights, T0=8, T1=16; out-of-range write must be ignored.
        cfg_write(0, 1'b0, 8);
        cfg_write(1, 1'b0, 16);
        cfg_write(19, 1'b1, 0);
        silent_run(smpack(4, 4, 4, 4));
        full_run("s2 two-tap", smpack(8, 8, 8, 8), 4'hF, pack4(6, 6, 6, 6));

        // 3: negative tap-1 sign written in the same cycle as the accept.
        silent_run(smpack(4, 4, 4, 4));
        start_run(smpack(8, 8, 8, 8), 4'hF, 1'b1, 1, cfgw(1'b1, 16));
        wait_result(res);
        check("s3 neg tap1", res, pack4(2, 2, 2, 2));
        release_result();
        silent_run(smpack(4, 4, 4, 4));
        full_run("s3 neg tap0 sample", smpack(-8, -8, -8, -8), 4'hF, pack4(-6, -6, -6, -6));

        // 4: result held under backpressure; input and cfg ignored meanwhile.
        do_reset();
        start_run(smpack(2, -11, 6, 13), 4'hF, 1'b0, 0, '0);
        wait_result(res);
        check("s4 first", res, pack4(2, -11, 6, 13));
        for (int i = 0; i < 10; i++) begin
            if (i == 2) begin
                in_valid = 1'b1;
                in_data  = smpack(1, 1, 1, 1);
                ch_en    = 4'hF;
            end
            if (i == 3) in_valid = 1'b0;
            if (i == 5) begin
                cfg_we   = 1'b1;
                cfg_addr = '0;
                cfg_data = cfgw(1'b1, 0);
            end
            if (i == 6) cfg_we = 1'b0;
            @(negedge clock);
            check("s4 hold data", out_data, pack4(2, -11, 6, 13));
            check("s4 hold in_ready", in_ready, 1'b0);
        end
        release_result();
        full_run("s4 after hold", smpack(9, -3, 1, 14), 4'hF, pack4(9, -3, 1, 14));

        // 5: disabled lanes output 0 and keep their history.
        do_reset();
        full_run("s5 partial enable", smpack(4, 4, 4, 12), 4'b0101, pack4(4, 0, 4, 0));
        cfg_write(0, 1'b0, 8);
        cfg_write(1, 1'b0, 16);
        full_run("s5 history", smpack(8, 8, 8, 8), 4'hF, pack4(6, 4, 6, 4));

        // 6: reset mid-run returns to idle with identity coefficients.
        cfg_write(0, 1'b0, 8);
        cfg_write(1, 1'b0, 16);
        start_run(smpack(6, 6, 6, 6), 4'hF, 1'b0, 0, '0);
        repeat (7) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("s6 in_ready", in_ready, 1'b1);
        check("s6 out_valid", out_valid, 1'b0);
        check("s6 busy", busy, 1'b0);
        full_run("s6 identity after reset", smpack(3, 3, 3, 3), 4'hF, pack4(3, 3, 3, 3));

        repeat (2) @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sc_fir_bank.md
Name: sc_fir_bank

Overview:
Parametrised multi-channel stochastic-computing FIR engine. It replaces the fixed 4-channel hardwired-weighted-average (HWA) filter instances with one block that has runtime-programmable tap weights and a per-channel enable. Each accepted sample vector is filtered on all enabled channels over one stochastic stream of 2^N cycles. The block generates its own random sources from a shared VDC counter, uses a valid/ready handshake on both sides, and returns binary results.

Parameters:
N, 12, precision in bits; stream length is 2^N cycles; samples are N+1 bits.
TAPS, 19, filter length (taps per channel).
CH, 4, number of parallel channels; all channels share coefficients and random sources.
AW, $clog2(TAPS), coefficient address width.

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  synchronous, active-high reset.
ch_en  in  CH  per-channel enable; sampled when an input is accepted.
in_valid  in  1  input sample vector valid.
in_ready  out  1  block can accept a sample vector.
in_data  in  CH*(N+1)  lane c = bits [(c+1)(N+1)-1 : c(N+1)]; sign-magnitude (bit N = sign, bits N-1:0 = magnitude).
cfg_we  in  1  coefficient write strobe.
cfg_addr  in  AW  tap index to write.
cfg_data  in  N+2  bit N+1 = coefficient sign; bits N:0 = cumulative threshold T_k, range 0..2^N.
out_valid  out  1  result vector valid.
out_ready  in  1  downstream accepts the result.
out_data  out  CH*(N+1)  per-lane result, two's complement, same lane packing as in_data.
busy  out  1  high while in RUN or DONE.

Behaviour:
- FSM states and transitions:
  - IDLE -> RUN on in_valid & in_ready.
  - RUN -> DONE when the stream counter t = 2^N-1.
  - DONE -> IDLE on out_ready.
  - in_ready = (state == IDLE); busy = !in_ready.
- On accept (per lane c):
  - If ch_en[c]: the lane's delay line shifts; tap 0 takes the new sample, tap k takes old tap k-1, and the oldest sample is dropped.
  - Accumulator acc[c] clears to 0. ch_en is registered as en_r.
  - Lanes with ch_en[c] = 0 keep their delay line unchanged.
- Random sources in RUN:
  - Counter t runs 0..2^N-1, cleared on accept.
  - sel = t.
  - R = bit-reverse(t), the N-bit VDC sequence.
- Tap select: k* is the lowest k with sel < T_k. If no tap qualifies, that cycle contributes nothing.
- Stochastic bit:
  - b = (mag[k*] > R), using an unsigned N-bit compare.
  - s = sample_sign[k*] XOR coef_sign[k*].
  - If b = 1: acc += (s ? -1 : +1).
- Accumulator width is N+2 bits, signed. The result is always in [-(2^N-1), 2^N-1], so no saturation logic is needed.
- Latency: acc is updated on every RUN edge. On the edge where t = 2^N-1, the final value (including that cycle's increment) loads into out_data and out_valid rises. out_valid is first high exactly 2^N cycles after the accept edge.
- Output hold: in DONE, out_data and out_valid hold until out_ready; the cycle after the handshake they return to out_valid = 0. out_data for lanes with en_r = 0 is 0. out_data keeps its last value when out_valid = 0.
- cfg_we:
  - Honoured only in IDLE: it writes coef_sign[cfg_addr] and T[cfg_addr] on the next edge.
  - Ignored in RUN/DONE, and ignored when cfg_addr >= TAPS.
  - If cfg_we and in_valid occur in the same IDLE cycle, both take effect; the new coefficient is used by that run.
- Coefficient contract (software's responsibility, not checked): T is non-decreasing, and T[TAPS-1] = 2^N for unit gain.
- Reset (in any state, including mid-run):
  - State goes to IDLE; t, acc, delay lines, out_data, en_r and out_valid clear to 0.
  - All T_k = 2^N and all coef_sign = 0. This makes tap 0 always selected, so the filter is an identity.
- Exactness: the VDC is a permutation of 0..2^N-1, so an identity run returns exactly ±magnitude.

Test Plan:
1. N=4, reset, no cfg, ch_en=4'hF. Lane inputs +5, -7 (5'b10111), +15, +0 -> after exactly 16 cycles out_valid=1 with lanes 5, -7 (5'b11001), 15, 0.
2. N=4. Write T0=8 (+), T1=16 (+), remaining taps T=16. Push samples +4, then +8 -> out = 6 on every lane (even R < 8 gives 4, odd R < 4 gives 2).
3. Same as scenario 2 but coef_sign[1]=1 -> out = 4 - 2 = 2. With tap-0 sample -8 instead -> out = -4 - 2 = -6.
4. Hold out_ready=0 for 10 cycles after out_valid:
   - out_data stable; in_ready=0.
   - in_valid and cfg_we pulsed during this window are ignored.
   - The result of a subsequent identity run is unaffected.
5. ch_en=4'b0101 -> lanes 1 and 3 output 0 and their delay lines are not shifted; verify by running a second run with ch_en=F in identity mode with 2-tap weights.
6. Assert reset at t=7 of a run -> next cycle: state IDLE, in_ready=1, out_valid=0, coefficients back to identity. A new sample +3 -> out 3.
